modinv_arbiter: RTL and testbench
=================================

MODINV_ARBITER -- requirements
Module: modinv_arbiter

Interface
REQ-001 Parameter: W, 4, operand/modulus width.
REQ-002 Parameter: TIMEOUT, 64, max cycles waiting on core_busy before abort.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 p  in  W  modulus; sampled at grant.
REQ-006 req0_valid / req1_valid  in  1  requester has operand pending.
REQ-007 req0_a / req1_a  in  W  operand A to invert.
REQ-008 req0_ready / req1_ready  out  1  grant; transfer occurs when valid && ready.
REQ-009 rsp0_valid / rsp1_valid  out  1  one-cycle result pulse to the owning requester.
REQ-010 rsp_b  out  W  inverse B, shared by both response channels.
REQ-011 rsp_err  out  1  result invalid; qualified by rspN_valid.
REQ-012 core_a, core_p  out  W  operand and modulus to shared ModInv core; held stable from ISSUE through CHECK.
REQ-013 core_start  out  1  core launch strobe.
REQ-014 core_busy  in  1  core computing.
REQ-015 core_b  in  W  core result.

Function
REQ-016 FSM states: IDLE, ISSUE, SETTLE, WAIT, CHECK, RESP.
REQ-017 IDLE: if any valid, assert ready to exactly one requester that cycle; latch A, p and owner id; go ISSUE, or RESP if rejected (REQ-023).
REQ-018 Arbitration: round-robin. On simultaneous valid, grant the requester not served last; after reset, req0 has priority.
REQ-019 ready is combinational from state and valid; it is 0 in every state except IDLE.
REQ-020 ISSUE: core_start=1 for exactly one cycle; go SETTLE.
REQ-021 SETTLE: one cycle; core_busy ignored; go WAIT.
REQ-022 WAIT: when core_busy==0, capture core_b and go CHECK. Timeout counter starts at 0 on entry and increments each WAIT cycle. On reaching TIMEOUT with busy still 1: rsp_err=1, rsp_b=0, go RESP.
REQ-023 Reject without launching core: A==0, A>=p, or p<2 gives rsp_err=1, rsp_b=0, go RESP. core_start stays 0.
REQ-024 CHECK: compute (A*B) mod p with a 2W-bit product. If the result is 1, rsp_err=0 and rsp_b=B; otherwise rsp_err=1 and rsp_b=B. Go RESP.
REQ-025 RESP: assert rspN_valid for the latched owner for one cycle; update the round-robin pointer; go IDLE.
REQ-026 A new request can be accepted in the first IDLE cycle after RESP. There are no back-to-back grants inside RESP.
REQ-027 Latency, accept to rsp_valid: 4 + (WAIT cycles) clocks. Reject path: 1 clock.
REQ-028 Inputs req_a and p may change after the grant cycle without effect on the operation in flight.
REQ-029 core_busy going high during IDLE is ignored.

Reset
REQ-030 On rst_n low, regardless of clk: state=IDLE, all ready/rsp_valid/core_start=0, rsp_b/rsp_err/core_a/core_p=0, timeout counter=0, RR pointer selects req0.
REQ-031 Reset mid-operation abandons the in-flight request; no rsp_valid is issued for it.
REQ-032 First grant can occur in the first clk edge after rst_n deasserts.

Verification
REQ-033 p=13, req0 A=2, core returns 7 -> rsp0_valid 1 cycle, rsp_b=7, rsp_err=0; core_start pulsed exactly once.
REQ-034 p=13, req0 A=12 and req1 A=3 both valid after reset -> req0 granted first (B=12); then req1 (B=9); each rsp on its own channel; err=0.
REQ-035 p=13, req1 A=0, then A=13 -> rsp1_valid with err=1, b=0, one cycle after accept; core_start never asserted.
REQ-036 Core model holds core_busy=1 forever -> rsp_err=1, rsp_b=0 exactly TIMEOUT WAIT cycles after entering WAIT; next request served normally.
REQ-037 Core model returns wrong B=5 for A=2, p=13 -> rsp_err=1, rsp_b=5.
REQ-038 rst_n pulsed low during WAIT -> outputs return to reset values immediately; no rsp_valid; fresh req0 A=4, p=13 afterwards -> B=10, err=0.

Source files
------------

// File: rtl/modinv_arbiter.sv
// -----------------------------------------------------------------------------
// modinv_arbiter
//
// Shares a single modular-inverse core between two requesters. One request is
// granted at a time with round-robin fairness. The operands are screened
// before the core is launched. The core is watched with a busy timeout, and
// its answer is verified by checking (A*B) mod p == 1 before it is reported.
//
// Handshake (valid/ready): a requester raises reqN_valid and holds reqN_a
// stable until it samples reqN_ready high. The transfer happens on the rising
// edge where valid && ready are both 1. ready is combinational from state and
// valid, and it is only ever high in IDLE. The response is a one-cycle
// rspN_valid pulse with no back-pressure. rsp_b and rsp_err are meaningful
// only while a rspN_valid is high.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   p                     modulus, sampled at grant
//   req0_valid/req0_a     requester 0 operand channel
//   req1_valid/req1_a     requester 1 operand channel
//   req0_ready/req1_ready grant
//   rsp0_valid/rsp1_valid one-cycle result pulse to the owning requester
//   rsp_b, rsp_err        shared result and error flag
//   core_a, core_p        operands to the shared core (held ISSUE..CHECK)
//   core_start            one-cycle launch strobe
//   core_busy, core_b     core status and result
//   dbg_state             current FSM state
// -----------------------------------------------------------------------------
module modinv_arbiter #(
   parameter int W       = 4,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] p,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_a,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_a,
   output logic         req0_ready,
   output logic         req1_ready,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   output logic [W-1:0] rsp_b,
   output logic         rsp_err,
   output logic [W-1:0] core_a,
   output logic [W-1:0] core_p,
   output logic         core_start,
   input  logic         core_busy,
   input  logic [W-1:0] core_b,
   output logic [2:0]   dbg_state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_CHECK  = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam int W2 = 2 * W;
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [2:0]    r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_p;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_rsp_b;
   logic          r_rsp_err;
   logic          r_owner;   // 0: req0, 1: req1
   logic          r_prio;    // 1: req1 wins a tie, 0: req0 wins a tie
   logic [CW-1:0] r_cnt;

   logic          w_idle;
   logic          w_any;
   logic          w_gnt1;
   logic [W-1:0]  w_sel_a;
   logic          w_reject;
   logic [W2-1:0] w_prod;
   logic [W2-1:0] w_mod;
   logic          w_ok;

   assign w_idle   = (r_state == S_IDLE);
   assign w_any    = req0_valid | req1_valid;
   // req1 wins when it is alone, or when both ask and it was not served last
   assign w_gnt1   = req1_valid & (~req0_valid | r_prio);
   assign w_sel_a  = w_gnt1 ? req1_a : req0_a;
   // Operands the core cannot invert are answered without launching it
   assign w_reject = (w_sel_a == '0) || (w_sel_a >= p) || (p < W'(2));

   // Gating with rst_n keeps the grant low while reset is held
   assign req0_ready = rst_n & w_idle & req0_valid & ~w_gnt1;
   assign req1_ready = rst_n & w_idle & w_gnt1;

   assign rsp0_valid = (r_state == S_RESP) & ~r_owner;
   assign rsp1_valid = (r_state == S_RESP) & r_owner;
   assign rsp_b      = r_rsp_b;
   assign rsp_err    = r_rsp_err;
   assign core_a     = r_a;
   assign core_p     = r_p;
   assign core_start = (r_state == S_ISSUE);
   assign dbg_state  = r_state;

   // Full-width product so the verification never wraps before the reduction
   assign w_prod = W2'(r_a) * W2'(r_b);
   assign w_mod  = (r_p == '0) ? '0 : (w_prod % W2'(r_p));
   assign w_ok   = (w_mod == W2'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_p       <= '0;
         r_b       <= '0;
         r_rsp_b   <= '0;
         r_rsp_err <= 1'b0;
         r_owner   <= 1'b0;
         r_prio    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_a     <= w_sel_a;
                  r_p     <= p;
                  r_owner <= w_gnt1;
                  r_cnt   <= '0;
                  if (w_reject) begin
                     r_rsp_b   <= '0;
                     r_rsp_err <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               // core_busy may not be valid yet right after the launch
               r_cnt   <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (!core_busy) begin
                  r_b     <= core_b;
                  r_state <= S_CHECK;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  // This was the TIMEOUT-th WAIT cycle with the core still busy
                  r_rsp_b   <= '0;
                  r_rsp_err <= 1'b1;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_CHECK: begin
               r_rsp_b   <= r_b;
               r_rsp_err <= ~w_ok;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               r_prio  <= ~r_owner;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_modinv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_modinv_arbiter
//
// Bench for modinv_arbiter. A transaction-level model predicts the grant,
// the response cycle, the response data and the core launch from the
// arbitration and latency rules. The model is checked every cycle. A small
// core model answers launches with a configurable latency, a wrong answer,
// or a permanent busy. Directed cases pin the model with literal values, and
// a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_modinv_arbiter;

   localparam int W  = 4;
   localparam int TO = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [W-1:0] p = '0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0] req0_a = '0, req1_a = '0;
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp_b, core_a, core_p;
   logic         rsp_err, core_start;
   logic         core_busy = 1'b0;
   logic [W-1:0] core_b = '0;
   logic [2:0]   dbg_state;

   modinv_arbiter #(.W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .p(p),
      .req0_valid(req0_valid), .req0_a(req0_a),
      .req1_valid(req1_valid), .req1_a(req1_a),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_b(rsp_b), .rsp_err(rsp_err),
      .core_a(core_a), .core_p(core_p), .core_start(core_start),
      .core_busy(core_busy), .core_b(core_b), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_pass = 0;
   int n_tot  = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      else n_pass++;
   endfunction

   function automatic int inv(int a, int pm);
      if (pm < 2) return 0;
      for (int b = 0; b < 16; b++) if (((a * b) % pm) == 1) return b;
      return 0;
   endfunction

   // ---------------- core model ----------------
   // mode 0: correct inverse after cm_lat, 1: returns cm_wrong, 2: busy forever
   int   cm_mode = 0, cm_lat = 1, cm_wrong = 0;
   int   core_rem = 0;
   bit   core_hang = 0;
   logic [W-1:0] core_nb = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         core_busy = 1'b0;
         core_b    = '0;
         core_rem  = 0;
         core_hang = 0;
      end else if (core_start) begin
         core_busy = 1'b1;
         core_rem  = cm_lat;
         core_hang = (cm_mode == 2);
         core_nb   = (cm_mode == 1) ? W'(cm_wrong) : W'(inv(int'(core_a), int'(core_p)));
      end else if (core_busy && !core_hang && core_rem > 0) begin
         core_rem--;
         if (core_rem == 0) begin
            core_busy = 1'b0;
            core_b    = core_nb;
         end
      end
   end

   // ---------------- reference model + compare ----------------
   int force_mode = 0, force_lat = 1, force_wrong = 0;
   bit m_idle = 1, m_prio = 0, m_own = 0, m_err = 0;
   int m_a = 0, m_p = 0, m_b = 0, m_resp = -1, m_start = -1, acc_cyc = 0;
   bit e_g0, e_g1, e_rsp;
   int n_start = 0, resp_cnt = 0, lr_cyc = 0, lr_b = 0, lr_err = 0, lr_ch = 0, r;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_idle = 1; m_prio = 0; m_resp = -1; m_start = -1;
         chk("rst_ready", {req1_ready, req0_ready}, 0);
         chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
         chk("rst_core_start", core_start, 0);
         chk("rst_rsp_b", rsp_b, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_core_a", core_a, 0);
         chk("rst_core_p", core_p, 0);
      end else begin
         e_g0 = 0; e_g1 = 0;
         if (m_idle && (req0_valid || req1_valid)) begin
            e_g1 = req1_valid && (!req0_valid || m_prio);
            e_g0 = !e_g1;
         end
         chk("ready", {req1_ready, req0_ready}, {e_g1, e_g0});
         e_rsp = !m_idle && (cyc == m_resp);
         chk("rsp_valid", {rsp1_valid, rsp0_valid}, {e_rsp && m_own, e_rsp && !m_own});
         chk("core_start", core_start, !m_idle && (cyc == m_start));
         if (e_rsp) begin
            chk("rsp_b", rsp_b, m_b);
            chk("rsp_err", rsp_err, m_err);
         end
         if (!m_idle && m_start >= 0 && cyc >= m_start && cyc < m_resp) begin
            chk("core_a_held", core_a, m_a);
            chk("core_p_held", core_p, m_p);
         end
         if (core_start) n_start++;
         if (rsp0_valid || rsp1_valid) begin
            resp_cnt++; lr_cyc = cyc; lr_b = rsp_b; lr_err = rsp_err; lr_ch = rsp1_valid;
         end
         if (e_rsp) begin
            m_idle = 1;
            m_prio = !m_own;
         end
         if (e_g0 || e_g1) begin
            m_own = e_g1;
            m_a = e_g1 ? int'(req1_a) : int'(req0_a);
            m_p = int'(p);
            acc_cyc = cyc;
            m_idle = 0;
            if (m_a == 0 || m_a >= m_p || m_p < 2) begin
               m_b = 0; m_err = 1; m_resp = cyc + 1; m_start = -1;
            end else begin
               if (force_mode >= 0) begin
                  cm_mode = force_mode; cm_lat = force_lat; cm_wrong = force_wrong;
               end else begin
                  r = $urandom_range(0, 15);
                  cm_mode  = (r == 0) ? 2 : (r < 4) ? 1 : 0;
                  cm_lat   = $urandom_range(1, 6);
                  cm_wrong = $urandom_range(0, 15);
               end
               m_start = cyc + 1;
               if (cm_mode == 2) begin
                  m_b = 0; m_err = 1; m_resp = cyc + 3 + TO;
               end else begin
                  m_b   = (cm_mode == 1) ? cm_wrong : inv(m_a, m_p);
                  m_err = (((m_a * m_b) % m_p) != 1);
                  // launch, settle, check, respond plus the WAIT cycles
                  m_resp = cyc + 4 + ((cm_lat > 1) ? cm_lat - 1 : 1);
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   bit acc0 = 0, acc1 = 0;
   always @(negedge clk) begin
      acc0 = rst_n && req0_valid && req0_ready;
      acc1 = rst_n && req1_valid && req1_ready;
   end
   always @(posedge clk) begin
      #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
   end

   task automatic go(input int ch, input int a, input int pv, input int fm, input int fl, input int fw);
      @(posedge clk); #1;
      force_mode = fm; force_lat = fl; force_wrong = fw; p = W'(pv);
      if (ch == 0) begin req0_a = W'(a); req0_valid = 1'b1; end
      else begin req1_a = W'(a); req1_valid = 1'b1; end
   endtask

   task automatic expect_rsp(input string nm, input int ch, input int b, input int err, input int lat);
      int n0;
      int i;
      n0 = resp_cnt;
      i = 0;
      while (resp_cnt == n0 && i < 200) begin @(posedge clk); i++; end
      if (resp_cnt == n0) chk({nm, "_timeout"}, 0, 1);
      else begin
         chk({nm, "_channel"}, lr_ch, ch);
         chk({nm, "_b"}, lr_b, b);
         chk({nm, "_err"}, lr_err, err);
         chk({nm, "_latency"}, lr_cyc - acc_cyc, lat);
      end
   endtask

   int plist[8] = '{13, 11, 7, 9, 15, 0, 1, 5};
   int s0, r0, k;

   initial begin
      repeat (3) @(posedge clk);
      // A=2, p=13: inverse 7, WAIT of 2 cycles, first grant right after reset
      #1; rst_n = 1'b1; p = 13; req0_a = 2; req0_valid = 1'b1;
      force_mode = 0; force_lat = 3;
      s0 = n_start;
      expect_rsp("basic", 0, 7, 0, 6);
      chk("basic_one_start", n_start - s0, 1);

      // Both valid after reset: req0 first (12), then req1 (3 -> 9)
      @(posedge clk); #1; rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; p = 13; force_mode = 0; force_lat = 2;
      req0_a = 12; req1_a = 3; req0_valid = 1'b1; req1_valid = 1'b1;
      expect_rsp("rr_first", 0, 12, 0, 5);
      expect_rsp("rr_second", 1, 9, 0, 5);

      // Rejects: A=0 and A=p, answered one cycle after accept, no launch
      s0 = n_start;
      go(1, 0, 13, 0, 1, 0);
      expect_rsp("rej_zero", 1, 0, 1, 1);
      go(1, 13, 13, 0, 1, 0);
      expect_rsp("rej_ge_p", 1, 0, 1, 1);
      chk("rej_no_start", n_start - s0, 0);

      // Core stuck busy: timeout after TO WAIT cycles, then normal service
      go(0, 2, 13, 2, 1, 0);
      expect_rsp("timeout", 0, 0, 1, 3 + TO);
      go(0, 4, 13, 0, 2, 0);
      expect_rsp("after_timeout", 0, 10, 0, 5);

      // Wrong answer from the core is flagged but still reported
      go(0, 2, 13, 1, 3, 5);
      expect_rsp("wrong_b", 0, 5, 1, 6);

      // Reset during WAIT
      s0 = n_start;
      go(0, 2, 13, 0, 6, 0);
      k = 0;
      while (n_start == s0 && k < 50) begin @(posedge clk); k++; end
      chk("mid_reset_launched", n_start - s0, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_rsp_b", rsp_b, 0);
      chk("async_core_a", core_a, 0);
      chk("async_core_p", core_p, 0);
      chk("async_core_start", core_start, 0);
      chk("async_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      r0 = resp_cnt;
      repeat (10) @(posedge clk);
      chk("abandoned_no_rsp", resp_cnt - r0, 0);
      go(0, 4, 13, 0, 2, 0);
      expect_rsp("post_reset", 0, 10, 0, 5);

      // Randomized traffic; p changes every cycle to show it only matters at grant
      force_mode = -1;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         p = W'(plist[$urandom_range(0, 7)]);
         if (!req0_valid && $urandom_range(0, 3) == 0) begin req0_a = W'($urandom_range(0, 15)); req0_valid = 1'b1; end
         if (!req1_valid && $urandom_range(0, 3) == 0) begin req1_a = W'($urandom_range(0, 15)); req1_valid = 1'b1; end
      end
      k = 0;
      while ((req0_valid || req1_valid || !m_idle) && k < 400) begin @(posedge clk); k++; end
      chk("drain", {req1_valid, req0_valid, !m_idle}, 0);
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
